// File: rtl/ioctl_stream_tx.sv
// Transmit side of the HPS ioctl download protocol: converts a valid/ready byte
// stream into framed ioctl_wr writes with hps_io-compatible spacing and ioctl_wait handling.
module ioctl_stream_tx #(
    parameter int unsigned AW        = 25,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned WR_GAP    = 3,
    parameter int unsigned TAIL_CYC  = 2
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [7:0]    index_in,
    input  logic [AW-1:0] length,
    input  logic          src_valid,
    input  logic [7:0]    src_data,
    output logic          src_ready,
    output logic          ioctl_download,
    output logic [7:0]    ioctl_index,
    output logic          ioctl_wr,
    output logic [AW-1:0] ioctl_addr,
    output logic [7:0]    ioctl_dout,
    input  logic          ioctl_wait,
    output logic          busy,
    output logic          done
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(WR_GAP - 1);
    localparam logic [CW-1:0] TAIL_LOAD  = CW'(TAIL_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_FETCH,
        S_WRITE,
        S_GAP,
        S_TAIL
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] len_q;
    logic [AW-1:0] last_addr;

    assign last_addr = len_q - AW'(1);

    // Byte handshake is only open while fetching; wait closes it without a register stage.
    assign src_ready = (state == S_FETCH) && !ioctl_wait;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            len_q          <= '0;
            ioctl_download <= 1'b0;
            ioctl_index    <= '0;
            ioctl_wr       <= 1'b0;
            ioctl_addr     <= '0;
            ioctl_dout     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            ioctl_wr <= 1'b0;
            done     <= 1'b0;
            if (abort && (state != S_IDLE)) begin
                state          <= S_IDLE;
                cnt            <= '0;
                ioctl_download <= 1'b0;
                busy           <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            if (length != '0) begin
                                len_q          <= length;
                                ioctl_index    <= index_in;
                                ioctl_addr     <= '0;
                                ioctl_download <= 1'b1;
                                busy           <= 1'b1;
                                cnt            <= SETUP_LOAD;
                                state          <= S_SETUP;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    S_SETUP: begin
                        if (cnt == '0) begin
                            state <= S_FETCH;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    S_FETCH: begin
                        if (src_valid && src_ready) begin
                            ioctl_dout <= src_data;
                            ioctl_wr   <= 1'b1;
                            state      <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        if (ioctl_addr == last_addr) begin
                            cnt   <= TAIL_LOAD;
                            state <= S_TAIL;
                        end else begin
                            ioctl_addr <= ioctl_addr + AW'(1);
                            if (WR_GAP == 0) begin
                                state <= S_FETCH;
                            end else begin
                                cnt   <= GAP_LOAD;
                                state <= S_GAP;
                            end
                        end
                    end
                    // Gap is a fixed count; ioctl_wait is deliberately ignored here.
                    S_GAP: begin
                        if (cnt == '0) begin
                            state <= S_FETCH;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    S_TAIL: begin
                        if (cnt == '0) begin
                            ioctl_download <= 1'b0;
                            done           <= 1'b1;
                            busy           <= 1'b0;
                            state          <= S_IDLE;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ioctl_stream_tx.sv
// Self-checking bench for ioctl_stream_tx: random byte streams and backpressure
// checked against a cycle-count/queue reference of the ioctl download framing.
module tb_ioctl_stream_tx;

    localparam int unsigned AW        = 25;
    localparam int          SETUP_CYC = 2;
    localparam int          WR_GAP    = 3;
    localparam int          TAIL_CYC  = 2;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [7:0]    index_in = '0;
    logic [AW-1:0] length = '0;
    logic          src_valid = 1'b0;
    logic [7:0]    src_data = '0;
    logic          src_ready;
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wait = 1'b0;
    logic          busy;
    logic          done;

    ioctl_stream_tx #(
        .AW(AW), .SETUP_CYC(SETUP_CYC), .WR_GAP(WR_GAP), .TAIL_CYC(TAIL_CYC)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .start(start), .abort(abort),
        .index_in(index_in), .length(length), .src_valid(src_valid),
        .src_data(src_data), .src_ready(src_ready), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .busy(busy), .done(done)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Observation log of one frame, filled by run_frame.
    logic [AW-1:0] wa_q[$];
    logic [7:0]    wd_q[$];
    int            wc_q[$];
    logic [7:0]    src_bytes[64];
    int dl_first, dl_last, done_cyc, done_cnt, viol, idx_bad, src_idx;
    int wait_drop, timeout, dl_after_abort, busy_after_abort;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Drives one transfer and records what the receiver side sees; cycle 1 is the first cycle after the start edge.
    task automatic run_frame(input int len, input logic [7:0] idx, input bit fixed,
                             input int valid_pct, input int wait_after, input int wait_len,
                             input int abort_after, input int restart_at);
        int cyc, wr_count, wait_left;
        bit drop_pending, prev_wait, aborting, acc;
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        for (int i = 0; i < 64; i++) src_bytes[i] = fixed ? 8'(8'hA0 + i) : 8'($urandom);
        dl_first = -1; dl_last = -1; done_cyc = -1; done_cnt = 0; viol = 0; idx_bad = 0;
        src_idx = 0; wait_drop = -1; timeout = 0; dl_after_abort = -1; busy_after_abort = -1;
        wr_count = 0; wait_left = 0; drop_pending = 0; prev_wait = 0; aborting = 0;
        start = 1'b1; index_in = idx; length = AW'(len); src_valid = 1'b0;
        tick();
        start = 1'b0;
        cyc = 1;
        forever begin
            if (ioctl_wr) begin
                wa_q.push_back(ioctl_addr); wd_q.push_back(ioctl_dout); wc_q.push_back(cyc);
                wr_count++;
                if (prev_wait) viol++;
            end
            if (ioctl_download) begin
                if (dl_first < 0) dl_first = cyc;
                dl_last = cyc;
                if (ioctl_index !== idx) idx_bad++;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (aborting) begin
                dl_after_abort = int'(ioctl_download);
                busy_after_abort = int'(busy);
                aborting = 0;
            end
            if (cyc >= 2 && !busy && !ioctl_download) break;
            if (cyc >= 2000) begin timeout = 1; break; end
            abort = 1'b0;
            if (abort_after > 0 && ioctl_wr && wr_count == abort_after) begin
                abort = 1'b1; aborting = 1;
            end
            if (ioctl_wr && wr_count == wait_after) wait_left = wait_len;
            if (wait_left > 0) begin
                ioctl_wait = 1'b1;
                wait_left--;
                if (wait_left == 0) drop_pending = 1;
            end else begin
                ioctl_wait = 1'b0;
                if (drop_pending) begin wait_drop = cyc; drop_pending = 0; end
            end
            start = (cyc == restart_at);
            if (start) begin index_in = ~idx; length = AW'(1); end
            src_valid = (int'($urandom_range(99)) < valid_pct);
            src_data = (src_idx < 64) ? src_bytes[src_idx] : 8'($urandom);
            #1;
            if (src_ready && ioctl_wait) viol++;
            acc = src_valid && src_ready;
            prev_wait = ioctl_wait;
            tick();
            if (acc) src_idx++;
            cyc++;
        end
        start = 1'b0; abort = 1'b0; src_valid = 1'b0; ioctl_wait = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({ioctl_download, ioctl_wr, busy, done, src_ready} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000",
                               {ioctl_download, ioctl_wr, busy, done, src_ready});
        end
        checks++;
        if (ioctl_addr !== '0 || ioctl_dout !== 8'h00 || ioctl_index !== 8'h00) begin
            errors++; $display("FAIL reset_data got addr=%0h dout=%0h index=%0h want 0",
                               ioctl_addr, ioctl_dout, ioctl_index);
        end
        reset = 1'b0;
        tick(); tick();
    endtask

    task automatic test_basic();
        int first_wr, last_wr;
        first_wr = SETUP_CYC + 2;
        last_wr  = first_wr + 3 * (WR_GAP + 2);
        run_frame(4, 8'h00, 1'b1, 100, -1, 0, -1, -1);
        checks++;
        if (timeout !== 0 || wc_q.size() !== 4) begin
            errors++; $display("FAIL basic_count got %0d writes timeout=%0d want 4", wc_q.size(), timeout);
        end
        for (int i = 0; i < wc_q.size() && i < 4; i++) begin
            checks++;
            if (wc_q[i] !== first_wr + i * (WR_GAP + 2) || wa_q[i] !== AW'(i) || wd_q[i] !== 8'(8'hA0 + i)) begin
                errors++; $display("FAIL basic_wr%0d got cyc=%0d addr=%0h dout=%0h want cyc=%0d addr=%0h dout=%0h",
                                   i, wc_q[i], wa_q[i], wd_q[i], first_wr + i * (WR_GAP + 2), i, 8'hA0 + i);
            end
        end
        checks++;
        if (dl_first !== 1 || dl_last !== last_wr + TAIL_CYC) begin
            errors++; $display("FAIL basic_download got %0d..%0d want 1..%0d", dl_first, dl_last, last_wr + TAIL_CYC);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== last_wr + TAIL_CYC + 1) begin
            errors++; $display("FAIL basic_done got cnt=%0d cyc=%0d want cnt=1 cyc=%0d",
                               done_cnt, done_cyc, last_wr + TAIL_CYC + 1);
        end
        tick(); tick();
        checks++;
        if (ioctl_addr !== AW'(3) || ioctl_dout !== 8'hA3 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_hold got addr=%0h dout=%0h busy=%b want 3 a3 0",
                               ioctl_addr, ioctl_dout, busy);
        end
    endtask

    task automatic test_index254();
        int bad;
        run_frame(8, 8'hFE, 1'b0, 100, -1, 0, -1, -1);
        checks++;
        if (idx_bad !== 0 || dl_first !== 1 || ioctl_index !== 8'hFE) begin
            errors++; $display("FAIL idx254_index got bad_cycles=%0d first=%0d index=%0h want 0 1 fe",
                               idx_bad, dl_first, ioctl_index);
        end
        bad = (wc_q.size() == 8) ? 0 : 1;
        for (int i = 0; i < wc_q.size(); i++)
            if (wa_q[i] !== AW'(i) || wd_q[i] !== src_bytes[i]) bad++;
        checks++;
        if (bad !== 0 || done_cnt !== 1) begin
            errors++; $display("FAIL idx254_writes got writes=%0d bad=%0d done=%0d want 8 0 1",
                               wc_q.size(), bad, done_cnt);
        end
    endtask

    task automatic test_wait();
        int bad;
        run_frame(6, 8'h10, 1'b0, 100, 2, 10, -1, -1);
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL wait_block got %0d accepts/strobes under wait want 0", viol);
        end
        checks++;
        if (wc_q.size() < 3 || wait_drop < 0 || wc_q[2] !== wait_drop + 1) begin
            errors++; $display("FAIL wait_resume got third_wr=%0d want %0d",
                               (wc_q.size() >= 3) ? wc_q[2] : -1, wait_drop + 1);
        end
        bad = (wc_q.size() == 6 && src_idx == 6) ? 0 : 1;
        for (int i = 0; i < wc_q.size(); i++)
            if (wa_q[i] !== AW'(i) || wd_q[i] !== src_bytes[i]) bad++;
        checks++;
        if (bad !== 0 || done_cnt !== 1) begin
            errors++; $display("FAIL wait_data got writes=%0d accepted=%0d bad=%0d done=%0d want 6 6 0 1",
                               wc_q.size(), src_idx, bad, done_cnt);
        end
    endtask

    task automatic test_gapped();
        int len, bad, spacing_bad;
        for (int it = 0; it < 5; it++) begin
            len = int'($urandom_range(20, 1));
            run_frame(len, 8'($urandom), 1'b0, 40, -1, 0, -1, -1);
            bad = (timeout == 0 && wc_q.size() == len && src_idx == len) ? 0 : 1;
            spacing_bad = 0;
            for (int i = 0; i < wc_q.size(); i++) begin
                if (wa_q[i] !== AW'(i) || wd_q[i] !== src_bytes[i]) bad++;
                if (i > 0 && wc_q[i] - wc_q[i-1] < WR_GAP + 2) spacing_bad++;
            end
            checks++;
            if (bad !== 0 || done_cnt !== 1) begin
                errors++; $display("FAIL gapped%0d_data got writes=%0d accepted=%0d bad=%0d done=%0d want %0d %0d 0 1",
                                   it, wc_q.size(), src_idx, bad, done_cnt, len, len);
            end
            checks++;
            if (spacing_bad !== 0) begin
                errors++; $display("FAIL gapped%0d_spacing got %0d short gaps want 0", it, spacing_bad);
            end
        end
    endtask

    task automatic test_abort();
        run_frame(6, 8'h22, 1'b0, 100, -1, 0, 2, -1);
        checks++;
        if (wc_q.size() !== 2 || dl_after_abort !== 0 || busy_after_abort !== 0 || done_cnt !== 0) begin
            errors++; $display("FAIL abort_stop got writes=%0d dl=%0d busy=%0d done=%0d want 2 0 0 0",
                               wc_q.size(), dl_after_abort, busy_after_abort, done_cnt);
        end
        checks++;
        if (src_ready !== 1'b0 || ioctl_wr !== 1'b0) begin
            errors++; $display("FAIL abort_idle got src_ready=%b wr=%b want 0 0", src_ready, ioctl_wr);
        end
        run_frame(3, 8'h23, 1'b0, 100, -1, 0, -1, -1);
        checks++;
        if (wc_q.size() !== 3 || wa_q[0] !== '0 || wd_q[0] !== src_bytes[0] || done_cnt !== 1) begin
            errors++; $display("FAIL abort_restart got writes=%0d first_addr=%0h done=%0d want 3 0 1",
                               wc_q.size(), (wa_q.size() > 0) ? wa_q[0] : AW'(0), done_cnt);
        end
        start = 1'b1; abort = 1'b1; length = AW'(5); index_in = 8'h77;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        checks++;
        if (ioctl_download !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_start_same got dl=%b busy=%b done=%b want 0 0 0",
                               ioctl_download, busy, done);
        end
    endtask

    task automatic test_zero_busy_reset();
        bit seen;
        run_frame(0, 8'h33, 1'b0, 100, -1, 0, -1, -1);
        checks++;
        if (done_cyc !== 1 || done_cnt !== 1 || dl_first !== -1 || wc_q.size() !== 0) begin
            errors++; $display("FAIL zero_len got done_cyc=%0d done=%0d dl_first=%0d writes=%0d want 1 1 -1 0",
                               done_cyc, done_cnt, dl_first, wc_q.size());
        end
        run_frame(4, 8'h44, 1'b0, 100, -1, 0, -1, 6);
        checks++;
        if (wc_q.size() !== 4 || idx_bad !== 0 || done_cnt !== 1 || done_cyc !== 22) begin
            errors++; $display("FAIL start_busy got writes=%0d idx_bad=%0d done=%0d done_cyc=%0d want 4 0 1 22",
                               wc_q.size(), idx_bad, done_cnt, done_cyc);
        end
        start = 1'b1; length = AW'(10); index_in = 8'h55; src_valid = 1'b1; src_data = 8'h5A;
        tick();
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (ioctl_wr) seen = 1;
            else tick();
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL reset_mid_write got no strobe within 50 cycles want strobe");
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({ioctl_download, ioctl_wr, busy, done, src_ready} !== 5'b0 ||
            ioctl_addr !== '0 || ioctl_dout !== 8'h00 || ioctl_index !== 8'h00) begin
            errors++; $display("FAIL reset_async got ctrl=%b addr=%0h dout=%0h index=%0h want 0",
                               {ioctl_download, ioctl_wr, busy, done, src_ready}, ioctl_addr, ioctl_dout, ioctl_index);
        end
        src_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_index254();
        test_wait();
        test_gapped();
        test_abort();
        test_zero_busy_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
